// File: rtl/uart_pkg.sv
// Shared types and helpers for the host-side UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_host_tx.sv
// Host-side UART transmitter: byte FIFO, CTS synchroniser and frame serialiser
// driving the SoC receive pin.
module uart_host_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          cts_n_i,
  output logic                          txd_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned          DIV       = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int                   DIV_W     = $clog2(DIV + 1);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [2:0]           LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]           LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [7:0]           DATA_MASK = 8'((1 << DATA_BITS) - 1);

  uart_tx_state_e   state_q;
  logic [DIV_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic             txd_q;
  logic             cts_meta_q, cts_sync_q;

  logic       fifo_full, fifo_empty, fifo_pop;
  logic [7:0] fifo_rdata, frame_data;
  logic       cts_ok, bit_done, start_ok;

  assign tx_ready = !fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (tx_valid && tx_ready),
    .pop_i   (fifo_pop),
    .wdata_i (tx_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // CTS resets to "not clear" so nothing leaves before the peer is ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_n_i;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_ok     = !cts_sync_q;
  assign bit_done   = (baud_cnt_q == '0);
  assign start_ok   = !fifo_empty && cts_ok;
  assign frame_data = fifo_rdata & DATA_MASK;

  // A new frame may start from IDLE, or on the final stop-bit cycle for zero gap.
  assign fifo_pop = start_ok &&
                    ((state_q == IDLE) ||
                     (state_q == STOP && bit_done && bit_idx_q == LAST_STOP));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      case (state_q)
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= shift_q[0];
        PARITY:  txd_q <= parity_q;
        default: txd_q <= 1'b1;
      endcase

      if (fifo_pop) begin
        state_q    <= START;
        baud_cnt_q <= DIV_LAST;
        bit_idx_q  <= '0;
        shift_q    <= frame_data;
        parity_q   <= (^frame_data) ^ (PARITY_ODD != 0);
      end else if (state_q != IDLE) begin
        if (!bit_done) begin
          baud_cnt_q <= baud_cnt_q - 1'b1;
        end else begin
          baud_cnt_q <= DIV_LAST;
          case (state_q)
            START: begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
            DATA: begin
              shift_q <= shift_q >> 1;
              if (bit_idx_q == LAST_DATA) begin
                state_q   <= (PARITY_EN != 0) ? PARITY : STOP;
                bit_idx_q <= '0;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end
            PARITY: begin
              state_q   <= STOP;
              bit_idx_q <= '0;
            end
            STOP: begin
              if (bit_idx_q == LAST_STOP) state_q <= IDLE;
              else                        bit_idx_q <= bit_idx_q + 1'b1;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign txd_o  = txd_q;
  assign busy_o = (state_q != IDLE) || !fifo_empty;

endmodule
